// File: rtl/display_scheduler.sv
// display_scheduler: chooses what the 3-digit FND shows.
// Sources by priority: error (highest), message, emulator page (lowest).
// Errors and messages are held for HOLD_TICKS ticks of TICK_DIV MCLK cycles.
// A message arriving while an error is shown waits in a one-deep pending slot.
// Optional build macro: DISPLAY_SCHEDULER_ERR_BLINK_EN blinks the error display
// once per tick; without it the error display is steady.
module display_scheduler #(
  parameter logic [23:0] TICK_DIV   = 24'd48000,
  parameter logic [15:0] HOLD_TICKS = 16'd1500
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        PAGE_VALID,
  input  logic [11:0] PAGE_VAL,
  input  logic        MSG_REQ,
  input  logic [11:0] MSG_VAL,
  input  logic        ERR_REQ,
  input  logic [7:0]  ERR_CODE,
  output logic [11:0] DISP_VAL,
  output logic        DISP_BLANK,
  output logic [1:0]  DISP_SRC,
  output logic        MSG_ACK,
  output logic        ERR_ACK
);

  typedef enum logic [1:0] {
    PAGE     = 2'd0,
    SHOW_MSG = 2'd1,
    SHOW_ERR = 2'd2
  } state_t;

  localparam logic [1:0] SRC_PAGE  = 2'b00;
  localparam logic [1:0] SRC_MSG   = 2'b01;
  localparam logic [1:0] SRC_ERR   = 2'b10;
  localparam logic [1:0] SRC_BLANK = 2'b11;

  state_t      state, state_n;
  logic [23:0] presc, presc_n;
  logic [15:0] ticks, ticks_n;
  logic [11:0] msg_latch, msg_n;
  logic [7:0]  err_latch, err_n;
  logic        pend_valid, pend_valid_n;
  logic [11:0] pend_val, pend_val_n;
  logic        restart;
  logic        tick;
  logic        expire;
  logic [11:0] disp_val_n;
  logic        disp_blank_n;
  logic [1:0]  disp_src_n;
  logic        msg_ack_n;
  logic        err_ack_n;
`ifdef DISPLAY_SCHEDULER_ERR_BLINK_EN
  logic        blink, blink_n;
`endif

  // State register; a synchronous reset returns to the page display.
  always_ff @(posedge MCLK) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (RESET) state <= PAGE;
    else       state <= state_n;
  end

  // Next-state, hold timer and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n      = state;
    msg_n        = msg_latch;
    err_n        = err_latch;
    pend_valid_n = pend_valid;
    pend_val_n   = pend_val;
    restart      = 1'b0;
    msg_ack_n    = 1'b0;
    err_ack_n    = 1'b0;
    presc_n      = presc;
    ticks_n      = ticks;
    disp_val_n   = 12'h000;
    disp_blank_n = 1'b1;
    disp_src_n   = SRC_BLANK;

    tick   = (state != PAGE) && (presc == TICK_DIV - 24'd1);
    expire = tick && (ticks == HOLD_TICKS - 16'd1);

    if (ERR_REQ) begin
      // Errors always win; a simultaneous message is parked as pending.
      err_n     = ERR_CODE;
      err_ack_n = 1'b1;
      state_n   = SHOW_ERR;
      restart   = 1'b1;
      if (MSG_REQ) begin
        pend_valid_n = 1'b1;
        pend_val_n   = MSG_VAL;
        msg_ack_n    = 1'b1;
      end
    end else if (MSG_REQ) begin
      msg_ack_n = 1'b1;
      if (state == SHOW_ERR && !expire) begin
        pend_valid_n = 1'b1;
        pend_val_n   = MSG_VAL;
      end else begin
        // Also covers an error expiring this cycle: the fresh message is the
        // newest one, so it is shown directly and supersedes any pending one.
        msg_n        = MSG_VAL;
        state_n      = SHOW_MSG;
        restart      = 1'b1;
        pend_valid_n = 1'b0;
      end
    end else if (expire) begin
      restart = 1'b1;
      if (state == SHOW_ERR && pend_valid) begin
        msg_n        = pend_val;
        pend_valid_n = 1'b0;
        state_n      = SHOW_MSG;
      end else begin
        state_n = PAGE;
      end
    end

    // Prescaler and tick counter; idle at zero in PAGE, never wrap.
    if (restart) begin
      presc_n = 24'd0;
      ticks_n = 16'd0;
    end else if (state != PAGE) begin
      if (tick) begin
        presc_n = 24'd0;
        ticks_n = ticks + 16'd1;
      end else begin
        presc_n = presc + 24'd1;
      end
    end

`ifdef DISPLAY_SCHEDULER_ERR_BLINK_EN
    blink_n = blink;
    if (restart)                      blink_n = 1'b0;
    else if (state == SHOW_ERR && tick) blink_n = ~blink;
`endif

    // Display values follow the state being entered, so they appear one
    // cycle after the accepting edge.
    case (state_n)
      SHOW_MSG: begin
        disp_val_n   = msg_n;
        disp_blank_n = 1'b0;
        disp_src_n   = SRC_MSG;
      end
      SHOW_ERR: begin
        disp_val_n   = {4'hE, err_n};
        disp_src_n   = SRC_ERR;
`ifdef DISPLAY_SCHEDULER_ERR_BLINK_EN
        disp_blank_n = blink_n;
`else
        disp_blank_n = 1'b0;
`endif
      end
      default: begin
        if (PAGE_VALID) begin
          disp_val_n   = PAGE_VAL;
          disp_blank_n = 1'b0;
          disp_src_n   = SRC_PAGE;
        end
      end
    endcase
  end

  // Datapath, latches and registered outputs.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      presc      <= 24'd0;
      ticks      <= 16'd0;
      msg_latch  <= 12'h000;
      err_latch  <= 8'h00;
      pend_valid <= 1'b0;
      pend_val   <= 12'h000;
      DISP_VAL   <= 12'h000;
      DISP_BLANK <= 1'b1;
      DISP_SRC   <= SRC_BLANK;
      MSG_ACK    <= 1'b0;
      ERR_ACK    <= 1'b0;
`ifdef DISPLAY_SCHEDULER_ERR_BLINK_EN
      blink      <= 1'b0;
`endif
    end else begin
      presc      <= presc_n;
      ticks      <= ticks_n;
      msg_latch  <= msg_n;
      err_latch  <= err_n;
      pend_valid <= pend_valid_n;
      pend_val   <= pend_val_n;
      DISP_VAL   <= disp_val_n;
      DISP_BLANK <= disp_blank_n;
      DISP_SRC   <= disp_src_n;
      MSG_ACK    <= msg_ack_n;
      ERR_ACK    <= err_ack_n;
`ifdef DISPLAY_SCHEDULER_ERR_BLINK_EN
      blink      <= blink_n;
`endif
    end
  end

endmodule
